// File: rtl/yazmac_yaz_kuyruk_pkg.sv
// Shared micro-op header for the retire-side write queue.
// It defines the bit layout of the retiring micro-op, packed LSB first:
// GECERLI, HY_YAZ, HY, HY_DEGER, DDY_YAZ, DDY_ADRES, DDY_VERI.
package yazmac_yaz_kuyruk_pkg;

    localparam int GECERLI_KON = 0;
    localparam int HY_YAZ_KON  = 1;
    localparam int HY_KON      = 2;

    function automatic int hy_deger_kon(input int hy_bit);
        return HY_KON + hy_bit;
    endfunction

    function automatic int ddy_yaz_kon(input int hy_bit, input int veri_bit);
        return hy_deger_kon(hy_bit) + veri_bit;
    endfunction

    function automatic int ddy_adres_kon(input int hy_bit, input int veri_bit);
        return ddy_yaz_kon(hy_bit, veri_bit) + 1;
    endfunction

    function automatic int ddy_veri_kon(input int hy_bit, input int veri_bit, input int adres_bit);
        return ddy_adres_kon(hy_bit, veri_bit) + adres_bit;
    endfunction

    function automatic int uis_bit(input int hy_bit, input int veri_bit, input int adres_bit);
        return ddy_veri_kon(hy_bit, veri_bit, adres_bit) + veri_bit;
    endfunction

endpackage

// File: rtl/yazmac_yaz_kuyruk_fifo.sv
// Generic synchronous FIFO that holds pending write-queue entries.
// With YAZMAC_YAZ_BYPASS_EN defined, the FIFO also exposes its storage,
// read pointer and occupancy so that the parent can search the pending writes.
module yazmac_yaz_fifo #(
    parameter int DERINLIK = 4,
    parameter int GENIS    = 8,
    localparam int PTR_BIT = $clog2(DERINLIK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [GENIS-1:0] din,
    output logic [GENIS-1:0] dout,
    output logic             full,
    output logic             empty
`ifdef YAZMAC_YAZ_BYPASS_EN
    ,
    output logic [DERINLIK-1:0][GENIS-1:0] girdiler,
    output logic [PTR_BIT-1:0]             bas_ptr,
    output logic [PTR_BIT:0]               doluluk
`endif
);

    localparam int SAYI_BIT = PTR_BIT + 1;

    logic [DERINLIK-1:0][GENIS-1:0] mem;
    logic [PTR_BIT-1:0]             oku_ptr;
    logic [PTR_BIT-1:0]             yaz_ptr;
    logic [SAYI_BIT-1:0]            sayi;
    logic                           yaz_en;
    logic                           oku_en;

    assign full   = (sayi == SAYI_BIT'(DERINLIK));
    assign empty  = (sayi == '0);
    assign yaz_en = push && !full;
    assign oku_en = pop && !empty;
    assign dout   = mem[oku_ptr];

`ifdef YAZMAC_YAZ_BYPASS_EN
    assign girdiler = mem;
    assign bas_ptr  = oku_ptr;
    assign doluluk  = sayi;
`endif

    // Storage carries no reset; only entries below the count are meaningful.
    always_ff @(posedge clk) begin
        if (yaz_en) mem[yaz_ptr] <= din;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oku_ptr <= '0;
            yaz_ptr <= '0;
            sayi    <= '0;
        end else begin
            if (yaz_en) yaz_ptr <= yaz_ptr + 1'b1;
            if (oku_en) oku_ptr <= oku_ptr + 1'b1;
            case ({yaz_en, oku_en})
                2'b10:   sayi <= sayi + 1'b1;
                2'b01:   sayi <= sayi - 1'b1;
                default: sayi <= sayi;
            endcase
        end
    end

endmodule

// File: rtl/yazmac_yaz_kuyruk.sv
// Retire-side write queue. It buffers the register-file and CSR writes of
// retiring micro-ops and drains them in order through the write ports.
// Optional macro YAZMAC_YAZ_BYPASS_EN adds a pending-write lookup port.
module yazmac_yaz_kuyruk
    import yazmac_yaz_kuyruk_pkg::*;
#(
    parameter int DERINLIK      = 4,
    parameter int HY_BIT        = 5,
    parameter int VERI_BIT      = 32,
    parameter int DDY_ADRES_BIT = 12,
    parameter int UIS_BIT       = uis_bit(HY_BIT, VERI_BIT, DDY_ADRES_BIT)
) (
    input  logic                     clk_g,
    input  logic                     rst_g,
    input  logic [UIS_BIT-1:0]       yoy_uis_g,
    output logic                     yoy_hazir_c,
    output logic                     yo_yaz_c,
    output logic [HY_BIT-1:0]        yo_yaz_hedef_c,
    output logic [VERI_BIT-1:0]      yo_yaz_veri_c,
    output logic                     ddy_yaz_c,
    output logic [DDY_ADRES_BIT-1:0] ddy_yaz_hedef_c,
    output logic [VERI_BIT-1:0]      ddy_yaz_veri_c,
    input  logic                     ddy_hazir_g
`ifdef YAZMAC_YAZ_BYPASS_EN
    ,
    input  logic [HY_BIT-1:0]        oku_adres_g,
    output logic                     oku_bekliyor_c,
    output logic [VERI_BIT-1:0]      oku_veri_c
`endif
);

    localparam int PTR_BIT  = $clog2(DERINLIK);
    localparam int HD_KON   = hy_deger_kon(HY_BIT);
    localparam int DY_KON   = ddy_yaz_kon(HY_BIT, VERI_BIT);
    localparam int DA_KON   = ddy_adres_kon(HY_BIT, VERI_BIT);
    localparam int DV_KON   = ddy_veri_kon(HY_BIT, VERI_BIT, DDY_ADRES_BIT);

    typedef struct packed {
        logic                     rf_yaz;
        logic                     csr_yaz;
        logic [HY_BIT-1:0]        hy;
        logic [VERI_BIT-1:0]      hy_deger;
        logic [DDY_ADRES_BIT-1:0] ddy_adres;
        logic [VERI_BIT-1:0]      ddy_veri;
    } girdi_t;

    localparam int GIRDI_BIT = $bits(girdi_t);

    girdi_t yeni;
    girdi_t bas;
    logic   dolu;
    logic   bos;
    logic   kabul;
    logic   aktif;
    logic   cikar;
    logic   yazildi;

    // x0 writes are dropped at the door so they can never reach the port.
    assign yeni.rf_yaz    = yoy_uis_g[HY_YAZ_KON] && (yoy_uis_g[HY_KON +: HY_BIT] != '0);
    assign yeni.csr_yaz   = yoy_uis_g[DY_KON];
    assign yeni.hy        = yoy_uis_g[HY_KON +: HY_BIT];
    assign yeni.hy_deger  = yoy_uis_g[HD_KON +: VERI_BIT];
    assign yeni.ddy_adres = yoy_uis_g[DA_KON +: DDY_ADRES_BIT];
    assign yeni.ddy_veri  = yoy_uis_g[DV_KON +: VERI_BIT];

    // Ready depends only on occupancy: a full queue never accepts through a pop.
    assign yoy_hazir_c = !dolu;
    assign kabul       = yoy_uis_g[GECERLI_KON] && yoy_hazir_c && (yeni.rf_yaz || yeni.csr_yaz);

    // Reset gates the ports so nothing is issued in a reset cycle.
    assign aktif = rst_g && !bos;
    assign cikar = aktif && (!bas.csr_yaz || ddy_hazir_g);

    assign yo_yaz_c        = aktif && bas.rf_yaz && !yazildi;
    assign yo_yaz_hedef_c  = yo_yaz_c ? bas.hy : '0;
    assign yo_yaz_veri_c   = yo_yaz_c ? bas.hy_deger : '0;
    assign ddy_yaz_c       = aktif && bas.csr_yaz;
    assign ddy_yaz_hedef_c = ddy_yaz_c ? bas.ddy_adres : '0;
    assign ddy_yaz_veri_c  = ddy_yaz_c ? bas.ddy_veri : '0;

`ifdef YAZMAC_YAZ_BYPASS_EN
    logic [DERINLIK-1:0][GIRDI_BIT-1:0] girdiler;
    logic [PTR_BIT-1:0]                 bas_ptr;
    logic [PTR_BIT:0]                   doluluk;
    logic [PTR_BIT-1:0]                 idx;
    girdi_t                             g;
`endif

    yazmac_yaz_fifo #(
        .DERINLIK (DERINLIK),
        .GENIS    (GIRDI_BIT)
    ) u_fifo (
        .clk      (clk_g),
        .rst_n    (rst_g),
        .push     (kabul),
        .pop      (cikar),
        .din      (yeni),
        .dout     (bas),
        .full     (dolu),
        .empty    (bos)
`ifdef YAZMAC_YAZ_BYPASS_EN
        ,
        .girdiler (girdiler),
        .bas_ptr  (bas_ptr),
        .doluluk  (doluluk)
`endif
    );

    // Register-file write fires once per entry, even while its CSR write stalls.
    always_ff @(posedge clk_g) begin
        if (!rst_g)        yazildi <= 1'b0;
        else if (cikar)    yazildi <= 1'b0;
        else if (yo_yaz_c) yazildi <= 1'b1;
    end

`ifdef YAZMAC_YAZ_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        oku_bekliyor_c = 1'b0;
        oku_veri_c     = '0;
        idx            = '0;
        g              = '0;
        for (int i = 0; i < DERINLIK; i++) begin
            idx = bas_ptr + PTR_BIT'(i);
            g   = girdiler[idx];
            if (((PTR_BIT+1)'(i) < doluluk) && g.rf_yaz && (g.hy == oku_adres_g) &&
                (oku_adres_g != '0)) begin
                oku_bekliyor_c = 1'b1;
                oku_veri_c     = g.hy_deger;
            end
        end
    end
`endif

endmodule

// File: tb/tb_yazmac_yaz_kuyruk.sv
// Self-checking bench for the retire-side write queue: a scoreboard of
// expected RF/CSR writes, a vector table, and directed corner sequences.
module tb_yazmac_yaz_kuyruk;
    import yazmac_yaz_kuyruk_pkg::*;

    localparam int HY_BIT   = 5;
    localparam int VERI_BIT = 32;
    localparam int ADR_BIT  = 12;
    localparam int DERINLIK = 4;
    localparam int UIS_BIT  = uis_bit(HY_BIT, VERI_BIT, ADR_BIT);

    logic                clk_g = 1'b0;
    logic                rst_g = 1'b0;
    logic [UIS_BIT-1:0]  yoy_uis_g = '0;
    logic                yoy_hazir_c;
    logic                yo_yaz_c;
    logic [HY_BIT-1:0]   yo_yaz_hedef_c;
    logic [VERI_BIT-1:0] yo_yaz_veri_c;
    logic                ddy_yaz_c;
    logic [ADR_BIT-1:0]  ddy_yaz_hedef_c;
    logic [VERI_BIT-1:0] ddy_yaz_veri_c;
    logic                ddy_hazir_g = 1'b0;
`ifdef YAZMAC_YAZ_BYPASS_EN
    logic [HY_BIT-1:0]   oku_adres_g = '0;
    logic                oku_bekliyor_c;
    logic [VERI_BIT-1:0] oku_veri_c;
`endif

    always #5 clk_g = ~clk_g;

    yazmac_yaz_kuyruk #(
        .DERINLIK(DERINLIK), .HY_BIT(HY_BIT), .VERI_BIT(VERI_BIT), .DDY_ADRES_BIT(ADR_BIT)
    ) dut (
        .clk_g           (clk_g),
        .rst_g           (rst_g),
        .yoy_uis_g       (yoy_uis_g),
        .yoy_hazir_c     (yoy_hazir_c),
        .yo_yaz_c        (yo_yaz_c),
        .yo_yaz_hedef_c  (yo_yaz_hedef_c),
        .yo_yaz_veri_c   (yo_yaz_veri_c),
        .ddy_yaz_c       (ddy_yaz_c),
        .ddy_yaz_hedef_c (ddy_yaz_hedef_c),
        .ddy_yaz_veri_c  (ddy_yaz_veri_c),
        .ddy_hazir_g     (ddy_hazir_g)
`ifdef YAZMAC_YAZ_BYPASS_EN
        ,
        .oku_adres_g     (oku_adres_g),
        .oku_bekliyor_c  (oku_bekliyor_c),
        .oku_veri_c      (oku_veri_c)
`endif
    );

    typedef struct { logic [HY_BIT-1:0]  hedef; logic [VERI_BIT-1:0] veri; } rf_bek_t;
    typedef struct { logic [ADR_BIT-1:0] hedef; logic [VERI_BIT-1:0] veri; } csr_bek_t;
    typedef struct {
        logic hy_yaz; logic [HY_BIT-1:0] hy; logic [VERI_BIT-1:0] d;
        logic dy; logic [ADR_BIT-1:0] a; logic [VERI_BIT-1:0] dv;
        bit rf_bek; bit csr_bek;
    } vek_t;

    rf_bek_t  rf_q[$];
    csr_bek_t csr_q[$];
    rf_bek_t  rb;
    csr_bek_t cb;
    vek_t     tablo[8];
    int       n_cmp = 0;
    int       n_err = 0;
    int       darbe;
    int       ddy_say;

    task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        n_cmp++;
        if (gercek !== beklenen) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", ad, gercek, beklenen);
        end
    endtask

    function automatic logic [UIS_BIT-1:0] mk(input logic hy_yaz, input logic [HY_BIT-1:0] hy,
        input logic [VERI_BIT-1:0] d, input logic dy, input logic [ADR_BIT-1:0] a,
        input logic [VERI_BIT-1:0] dv);
        logic [UIS_BIT-1:0] u;
        u = '0;
        u[GECERLI_KON] = 1'b1;
        u[HY_YAZ_KON]  = hy_yaz;
        u[HY_KON +: HY_BIT] = hy;
        u[hy_deger_kon(HY_BIT) +: VERI_BIT] = d;
        u[ddy_yaz_kon(HY_BIT, VERI_BIT)] = dy;
        u[ddy_adres_kon(HY_BIT, VERI_BIT) +: ADR_BIT] = a;
        u[ddy_veri_kon(HY_BIT, VERI_BIT, ADR_BIT) +: VERI_BIT] = dv;
        return u;
    endfunction

    // Called and returns at posedge+1; the op is accepted at the edge it waits for.
    task automatic gonder(input logic hy_yaz, input logic [HY_BIT-1:0] hy, input logic [VERI_BIT-1:0] d,
        input logic dy, input logic [ADR_BIT-1:0] a, input logic [VERI_BIT-1:0] dv,
        input bit rf_bek, input bit csr_bek);
        rf_bek_t  r;
        csr_bek_t c;
        yoy_uis_g = mk(hy_yaz, hy, d, dy, a, dv);
        for (int t = 0; t < 50 && yoy_hazir_c !== 1'b1; t++) begin
            @(posedge clk_g); #1;
        end
        if (yoy_hazir_c !== 1'b1) begin
            chk("kabul_zamanasimi", 64'(yoy_hazir_c), 64'd1);
            yoy_uis_g = '0;
            return;
        end
        if (rf_bek)  begin r.hedef = hy; r.veri = d;  rf_q.push_back(r);  end
        if (csr_bek) begin c.hedef = a;  c.veri = dv; csr_q.push_back(c); end
        @(posedge clk_g); #1;
        yoy_uis_g = '0;
    endtask

    task automatic bosalt();
        ddy_hazir_g = 1'b1;
        for (int t = 0; t < 100 && (rf_q.size() != 0 || csr_q.size() != 0); t++) begin
            @(posedge clk_g); #1;
        end
        chk("bosalt_kalan", 64'(rf_q.size() + csr_q.size()), 64'd0);
        @(negedge clk_g);
        chk("bos_cikis", 64'(|{yo_yaz_c, ddy_yaz_c, yo_yaz_hedef_c, yo_yaz_veri_c,
                              ddy_yaz_hedef_c, ddy_yaz_veri_c}), 64'd0);
        @(posedge clk_g); #1;
    endtask

    // Scoreboard: every write seen on a port must match the oldest expected one.
    always @(negedge clk_g) begin
        if (yo_yaz_c === 1'b1) begin
            if (rf_q.size() == 0) chk("rf_beklenmeyen", 64'd1, 64'd0);
            else begin
                rb = rf_q.pop_front();
                chk("rf_hedef", 64'(yo_yaz_hedef_c), 64'(rb.hedef));
                chk("rf_veri",  64'(yo_yaz_veri_c),  64'(rb.veri));
            end
        end
        if (ddy_yaz_c === 1'b1 && ddy_hazir_g === 1'b1) begin
            if (csr_q.size() == 0) chk("csr_beklenmeyen", 64'd1, 64'd0);
            else begin
                cb = csr_q.pop_front();
                chk("csr_hedef", 64'(ddy_yaz_hedef_c), 64'(cb.hedef));
                chk("csr_veri",  64'(ddy_yaz_veri_c),  64'(cb.veri));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tablo[0] = '{1'b1, 5'd1,  32'h0000_0001, 1'b0, 12'h000, 32'h0,          1, 0};
        tablo[1] = '{1'b0, 5'd9,  32'h9999_9999, 1'b0, 12'h000, 32'h0,          0, 0};
        tablo[2] = '{1'b1, 5'd0,  32'h0000_0BAD, 1'b1, 12'h305, 32'h0000_CAFE,  0, 1};
        tablo[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 12'hFFF, 32'h0000_0000,  1, 1};
        tablo[4] = '{1'b0, 5'd4,  32'h4444_4444, 1'b1, 12'h001, 32'h1234_5678,  0, 1};
        tablo[5] = '{1'b1, 5'd16, 32'h8000_0000, 1'b0, 12'h000, 32'h0,          1, 0};
        tablo[6] = '{1'b1, 5'd0,  32'h6666_6666, 1'b0, 12'h000, 32'h0,          0, 0};
        tablo[7] = '{1'b1, 5'd2,  32'h0BAD_F00D, 1'b1, 12'h7C0, 32'h5A5A_A5A5,  1, 1};

        // Reset state
        repeat (2) @(posedge clk_g);
        @(negedge clk_g);
        chk("reset_yo",  64'(yo_yaz_c),  64'd0);
        chk("reset_ddy", 64'(ddy_yaz_c), 64'd0);
        @(posedge clk_g); #1;
        rst_g = 1'b1;
        @(negedge clk_g);
        chk("reset_hazir", 64'(yoy_hazir_c), 64'd1);
        @(posedge clk_g); #1;

        // Single RF write: one-cycle latency, exactly one pulse
        ddy_hazir_g = 1'b1;
        gonder(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0, 1, 0);
        darbe = 0;
        @(negedge clk_g);
        chk("tek_gecikme", 64'(yo_yaz_c), 64'd1);
        darbe += int'(yo_yaz_c);
        repeat (3) begin @(negedge clk_g); darbe += int'(yo_yaz_c); end
        chk("tek_darbe", 64'(darbe), 64'd1);
        @(posedge clk_g); #1;

        // x0 writes never allocate or reach the port
        for (int i = 0; i < DERINLIK + 1; i++) gonder(1'b1, 5'd0, 32'h1234, 1'b0, 12'h0, 32'h0, 0, 0);
        darbe = 0;
        repeat (3) begin @(negedge clk_g); darbe += int'(yo_yaz_c); end
        chk("x0_darbe", 64'(darbe), 64'd0);
        chk("x0_hazir", 64'(yoy_hazir_c), 64'd1);
        @(posedge clk_g); #1;

        // CSR stall: RF pulse once, CSR held 4 cycles, pop on the 4th
        ddy_hazir_g = 1'b0;
        gonder(1'b1, 5'd7, 32'hA5A5_0007, 1'b1, 12'h300, 32'h0000_1800, 1, 1);
        darbe = 0; ddy_say = 0;
        for (int k = 0; k < 4; k++) begin
            ddy_hazir_g = (k == 3);
            @(negedge clk_g);
            darbe   += int'(yo_yaz_c);
            ddy_say += int'(ddy_yaz_c);
            chk("csr_sabit_hedef", 64'(ddy_yaz_hedef_c), 64'h300);
            @(posedge clk_g); #1;
        end
        ddy_hazir_g = 1'b0;
        @(negedge clk_g);
        chk("csr_cikti", 64'(ddy_yaz_c), 64'd0);
        chk("csr_yo_darbe", 64'(darbe), 64'd1);
        chk("csr_ddy_sure", 64'(ddy_say), 64'd4);
        @(posedge clk_g); #1;

        // Full queue: fifth op waits for exactly one pop
        for (int i = 0; i < DERINLIK; i++)
            gonder(1'b0, 5'd0, 32'h0, 1'b1, 12'(12'h340 + i), 32'(32'h100 + i), 0, 1);
        @(negedge clk_g);
        chk("dolu_hazir", 64'(yoy_hazir_c), 64'd0);
        @(posedge clk_g); #1;
        yoy_uis_g = mk(1'b0, 5'd0, 32'h0, 1'b1, 12'h344, 32'h104);
        repeat (2) begin
            @(negedge clk_g);
            chk("dolu_bekle", 64'(yoy_hazir_c), 64'd0);
            @(posedge clk_g); #1;
        end
        ddy_hazir_g = 1'b1;
        @(posedge clk_g); #1;
        ddy_hazir_g = 1'b0;
        @(negedge clk_g);
        chk("dolu_yer_acildi", 64'(yoy_hazir_c), 64'd1);
        cb.hedef = 12'h344; cb.veri = 32'h104; csr_q.push_back(cb);
        @(posedge clk_g); #1;
        yoy_uis_g = '0;
        @(negedge clk_g);
        chk("dolu_tekrar", 64'(yoy_hazir_c), 64'd0);
        @(posedge clk_g); #1;
        bosalt();

        // Vector table, back to back with the CSR unit always ready
        ddy_hazir_g = 1'b1;
        for (int i = 0; i < 8; i++)
            gonder(tablo[i].hy_yaz, tablo[i].hy, tablo[i].d, tablo[i].dy, tablo[i].a, tablo[i].dv,
                   tablo[i].rf_bek, tablo[i].csr_bek);
        bosalt();

`ifdef YAZMAC_YAZ_BYPASS_EN
        // Bypass lookup returns the youngest pending value
        ddy_hazir_g = 1'b0;
        oku_adres_g = 5'd3;
        gonder(1'b1, 5'd3, 32'h11, 1'b1, 12'h320, 32'h1, 1, 1);
        gonder(1'b1, 5'd3, 32'h22, 1'b1, 12'h321, 32'h2, 1, 1);
        #1;
        chk("bypass_isabet", 64'(oku_bekliyor_c), 64'd1);
        chk("bypass_veri",   64'(oku_veri_c),     64'h22);
        oku_adres_g = 5'd0;
        #1;
        chk("bypass_x0",      64'(oku_bekliyor_c), 64'd0);
        chk("bypass_x0_veri", 64'(oku_veri_c),     64'd0);
        oku_adres_g = 5'd4;
        #1;
        chk("bypass_iska", 64'(oku_bekliyor_c), 64'd0);
        @(posedge clk_g); #1;
        bosalt();
`endif

        // Reset mid-operation with a stalled CSR write and three entries pending
        ddy_hazir_g = 1'b0;
        for (int i = 0; i < 3; i++)
            gonder(1'b1, 5'(10 + i), 32'(32'h500 + i), 1'b1, 12'(12'h310 + i), 32'(32'h600 + i), 1, 1);
        @(negedge clk_g);
        chk("rst_oncesi_ddy", 64'(ddy_yaz_c), 64'd1);
        @(posedge clk_g); #1;
        rf_q.delete();
        csr_q.delete();
        rst_g = 1'b0;
        ddy_hazir_g = 1'b1;
        @(negedge clk_g);
        chk("rst_dongu_ddy", 64'(ddy_yaz_c), 64'd0);
        chk("rst_dongu_yo",  64'(yo_yaz_c),  64'd0);
        @(posedge clk_g); #1;
        rst_g = 1'b1;
        @(negedge clk_g);
        chk("rst_sonra_hazir", 64'(yoy_hazir_c), 64'd1);
        chk("rst_sonra_cikis", 64'(|{yo_yaz_c, ddy_yaz_c, yo_yaz_hedef_c, yo_yaz_veri_c,
                                    ddy_yaz_hedef_c, ddy_yaz_veri_c}), 64'd0);
        repeat (5) @(posedge clk_g);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/yazmac_yaz_kuyruk.md
YAZMAC_YAZ_KUYRUK -- requirements
Module: yazmac_yaz_kuyruk

Interface
REQ-001 Parameter: DERINLIK, default 4, queue entries (power of two, >=2).
REQ-002 Parameter: HY_BIT, default 5, register-file address width.
REQ-003 Parameter: VERI_BIT, default 32, write-data width.
REQ-004 Parameter: DDY_ADRES_BIT, default 12, CSR address width.
REQ-005 clk_g  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_g  input  1  synchronous, active-low reset.
REQ-007 yoy_uis_g  input  UIS_BIT  retiring micro-op; fields GECERLI, HY_YAZ, HY, HY_DEGER, DDY_YAZ, DDY_ADRES, DDY_VERI.
REQ-008 yoy_hazir_c  output  1  queue can accept a micro-op this cycle.
REQ-009 yo_yaz_c / yo_yaz_hedef_c / yo_yaz_veri_c  output  1 / HY_BIT / VERI_BIT  register-file write port.
REQ-010 ddy_yaz_c / ddy_yaz_hedef_c / ddy_yaz_veri_c  output  1 / DDY_ADRES_BIT / VERI_BIT  CSR write port.
REQ-011 ddy_hazir_g  input  1  CSR unit accepts the presented write this cycle.
REQ-012 oku_adres_g  input  HY_BIT  bypass lookup address (only with macro, REQ-030).
REQ-013 oku_bekliyor_c / oku_veri_c  output  1 / VERI_BIT  pending-write hit and value (only with macro).

Function
REQ-014 Accept: micro-op SHALL be taken when GECERLI && yoy_hazir_c; yoy_hazir_c = (count != DERINLIK), no same-cycle pop-through.
REQ-015 Entry SHALL store rf_yaz = HY_YAZ && (HY != 0), csr_yaz = DDY_YAZ, plus addresses and data; x0 writes never reach the write port.
REQ-016 Accepted micro-op with rf_yaz=0 and csr_yaz=0 SHALL be consumed without allocating an entry.
REQ-017 Outputs SHALL be driven from the head entry only; latency accept->port = 1 cycle when queue empty; no combinational input->write-port path.
REQ-018 yo_yaz_c SHALL assert exactly one cycle per entry: first cycle the entry is head with rf_yaz=1; a yazildi flag SHALL suppress repeats while the CSR write stalls.
REQ-019 ddy_yaz_c SHALL assert while head has csr_yaz=1 and hold address/data stable until ddy_hazir_g=1.
REQ-020 Pop: head SHALL retire at the edge where (csr_yaz=0) or (ddy_hazir_g=1); yazildi clears on pop.
REQ-021 Entries SHALL drain strictly in acceptance order; one pop per cycle maximum.
REQ-022 Simultaneous accept and pop SHALL leave count unchanged; pointers wrap modulo DERINLIK.
REQ-023 count width clog2(DERINLIK)+1; count SHALL never exceed DERINLIK nor go below 0.
REQ-024 Write-port outputs SHALL be zero when queue empty.

Reset
REQ-025 rst_g=0 at an edge SHALL clear count, read/write pointers and yazildi; queue contents are don't-care.
REQ-026 During and after reset all write-port outputs SHALL be 0 and yoy_hazir_c SHALL be 1 from the first cycle after reset.
REQ-027 Reset mid-operation SHALL discard all pending entries, including a stalled CSR write; no write is issued in the reset cycle.

Configuration
REQ-028 Macro YAZMAC_YAZ_BYPASS_EN SHALL gate the bypass lookup.
REQ-029 Defined: oku_bekliyor_c=1 when any valid entry has rf_yaz=1 and HY==oku_adres_g (address 0 never hits); oku_veri_c = data of youngest such entry; combinational, zero when no hit.
REQ-030 Undefined: oku_adres_g, oku_bekliyor_c, oku_veri_c SHALL not exist; all other behaviour identical.

Structure
REQ-031 Field offsets/widths (GECERLI, HY, HY_DEGER, DDY_*) SHALL come from the shared micro-op header; queue entry layout defined locally.
REQ-032 One sub-module natural: yazmac_yaz_fifo (generic synchronous FIFO, DERINLIK x entry width, count/full/empty).

Verification
REQ-033 Single op HY=5, HY_DEGER=0xDEADBEEF, DDY_YAZ=0 -> next cycle yo_yaz_c=1, hedef=5, veri=0xDEADBEEF, for exactly one cycle.
REQ-034 Op HY_YAZ=1, HY=0 -> yo_yaz_c never asserts; count stays 0.
REQ-035 CSR op DDY_ADRES=0x300, ddy_hazir_g low 3 cycles, HY=7 -> yo_yaz_c one pulse, ddy_yaz_c held 4 cycles, pop on 4th.
REQ-036 Hold ddy_hazir_g=0, push 5 CSR ops (DERINLIK=4) -> yoy_hazir_c=0 after 4th; 5th accepted only after one pop; order preserved.
REQ-037 With YAZMAC_YAZ_BYPASS_EN: queue HY=3 values 0x11 then 0x22, oku_adres_g=3 -> oku_bekliyor_c=1, oku_veri_c=0x22; oku_adres_g=0 -> 0.
REQ-038 Reset asserted with 3 pending entries and CSR stall -> next cycle all ports 0, yoy_hazir_c=1, no further writes.
